// File: rtl/memory_port_arbiter.sv
// Serialises one optional data access then one instruction fetch onto a single bus per pipeline advance.
// IDLE->DONE takes 2 cycles (fetch only) or 3 (data + fetch) plus ack waits; mem_busy stalls the core until DONE.
module memory_port_arbiter #(
  parameter int DATA_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [DATA_SIZE-1:0]     inst_addr,
  output logic [31:0]              inst,
  input  logic                     data_rd_en,
  input  logic                     data_wr_en,
  input  logic [DATA_SIZE-1:0]     data_addr,
  input  logic [DATA_SIZE-1:0]     data_wr_data,
  input  logic [DATA_SIZE/8-1:0]   data_byte_en,
  output logic [DATA_SIZE-1:0]     data_rd_data,
  output logic                     mem_busy,
  output logic                     bus_error,
  output logic                     bus_req,
  output logic                     bus_we,
  output logic [DATA_SIZE-1:0]     bus_addr,
  output logic [DATA_SIZE-1:0]     bus_wr_data,
  output logic [DATA_SIZE/8-1:0]   bus_byte_en,
  input  logic                     bus_ack,
  input  logic [DATA_SIZE-1:0]     bus_rd_data
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_INST = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic [CW-1:0]        r_wait_cnt;
  logic [31:0]          r_inst;
  logic [DATA_SIZE-1:0] r_data_rd_data;
  logic                 r_bus_error;
  logic                 w_in_access;
  logic                 w_timeout;
  logic                 w_access_end;
  logic [DATA_SIZE-1:0] w_rdata;

  assign w_in_access  = (r_state == S_DATA) || (r_state == S_INST);
  // An ack arriving on the final allowed cycle wins over the timeout.
  assign w_timeout    = w_in_access && !bus_ack && (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));
  assign w_access_end = w_in_access && (bus_ack || w_timeout);
  assign w_rdata      = bus_ack ? bus_rd_data : '0;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  w_next_state = (data_rd_en || data_wr_en) ? S_DATA : S_INST;
      S_DATA:  if (w_access_end) w_next_state = S_INST;
      S_INST:  if (w_access_end) w_next_state = S_DONE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req     = 1'b0;
    bus_we      = 1'b0;
    bus_addr    = '0;
    bus_wr_data = '0;
    bus_byte_en = '0;
    if (r_state == S_DATA) begin
      bus_req     = 1'b1;
      bus_we      = data_wr_en;
      bus_addr    = data_addr;
      bus_wr_data = data_wr_data;
      bus_byte_en = data_byte_en;
    end else if (r_state == S_INST) begin
      bus_req     = 1'b1;
      bus_addr    = inst_addr;
      bus_byte_en = '1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_wait_cnt     <= '0;
      r_inst         <= '0;
      r_data_rd_data <= '0;
      r_bus_error    <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_bus_error <= w_timeout;
      if (w_next_state != r_state)
        r_wait_cnt <= '0;
      else if (w_in_access && !bus_ack)
        r_wait_cnt <= r_wait_cnt + CW'(1);
      if (r_state == S_DATA && w_access_end && !data_wr_en)
        r_data_rd_data <= w_rdata;
      if (r_state == S_INST && w_access_end)
        r_inst <= w_rdata[31:0];
    end
  end

  assign inst         = r_inst;
  assign data_rd_data = r_data_rd_data;
  assign bus_error    = r_bus_error;
  assign mem_busy     = (r_state != S_DONE);

endmodule
